// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
//
// Purpose:
//   Holds the architectural NZCV flag register and evaluates each instruction's
//   4-bit Arm condition field against it. It gates the instruction's register
//   write, memory write and PC redirect with the result. The unit sits between
//   the execute-stage ALU and the memory/writeback stage. Every output is
//   registered, so results appear one cycle after the instruction is accepted.
//
// Optional feature:
//   COND_PERF_CNT_EN  When defined, adds the exec_count and squash_count
//                     saturating performance counters.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   stall          in   hold all state; inputs are ignored this cycle
//   flush          in   squash the incoming instruction (wins over stall)
//   in_valid       in   an instruction is present on the inputs
//   cond[3:0]      in   Arm condition field (instruction bits [31:28])
//   flag_write[1:0] in  bit1 = update N,Z; bit0 = update C,V
//   alu_flags[3:0] in   {N,Z,C,V} from the ALU for this instruction
//   pc_src_in      in   instruction requests a PC redirect
//   reg_write_in   in   instruction requests a register write
//   mem_write_in   in   instruction requests a memory write
//   out_valid      out  an instruction was accepted last cycle
//   cond_ex        out  the accepted instruction's condition passed
//   pc_src         out  pc_src_in gated by the condition
//   reg_write      out  reg_write_in gated by the condition
//   mem_write      out  mem_write_in gated by the condition
//   illegal_cond   out  the accepted instruction had cond == 4'b1111
//   flags[3:0]     out  current NZCV register {N,Z,C,V}
//   exec_count     out  (COND_PERF_CNT_EN) accepted instructions that passed
//   squash_count   out  (COND_PERF_CNT_EN) accepted instructions that failed
//
// Handshake: there is no backpressure from this unit. An instruction is
// accepted on a rising edge when in_valid & ~stall & ~flush. out_valid then
// qualifies the remaining outputs for one cycle; while stall is high (and
// flush low) every register holds, so the consumer sees the same out_valid
// and enables repeated.
// -----------------------------------------------------------------------------
module cond_unit #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       cond,
  input  logic [1:0]       flag_write,
  input  logic [3:0]       alu_flags,
  input  logic             pc_src_in,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
`ifdef COND_PERF_CNT_EN
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] squash_count,
`endif
  output logic             out_valid,
  output logic             cond_ex,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             illegal_cond,
  output logic [3:0]       flags
);

  logic [3:0] flags_q, flags_d;
  logic       out_valid_q, out_valid_d;
  logic       cond_ex_q, cond_ex_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       illegal_q, illegal_d;

  logic accept;
  logic pass;
  logic n_f, z_f, c_f, v_f;

  assign accept = in_valid & ~stall & ~flush;

  // Condition uses the register value before this edge's update, so an
  // instruction's own flag write never affects its own condition.
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = z_f;
      4'b0001: pass = ~z_f;
      4'b0010: pass = c_f;
      4'b0011: pass = ~c_f;
      4'b0100: pass = n_f;
      4'b0101: pass = ~n_f;
      4'b0110: pass = v_f;
      4'b0111: pass = ~v_f;
      4'b1000: pass = c_f & ~z_f;
      4'b1001: pass = ~c_f | z_f;
      4'b1010: pass = (n_f == v_f);
      4'b1011: pass = (n_f != v_f);
      4'b1100: pass = ~z_f & (n_f == v_f);
      4'b1101: pass = z_f | (n_f != v_f);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;  // 4'b1111 is reserved and never executes
    endcase
  end

  always_comb begin
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    cond_ex_d   = cond_ex_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
      cond_ex_d   = 1'b0;
      pc_src_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      // With in_valid low these all fall to zero and the flags hold.
      out_valid_d = in_valid;
      cond_ex_d   = in_valid & pass;
      pc_src_d    = in_valid & pass & pc_src_in;
      reg_write_d = in_valid & pass & reg_write_in;
      mem_write_d = in_valid & pass & mem_write_in;
      illegal_d   = in_valid & (cond == 4'b1111);
      if (accept && pass) begin
        if (flag_write[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_write[0]) flags_d[1:0] = alu_flags[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= FLAGS_RESET;
      out_valid_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      cond_ex_q   <= cond_ex_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign flags        = flags_q;
  assign out_valid    = out_valid_q;
  assign cond_ex      = cond_ex_q;
  assign pc_src       = pc_src_q;
  assign reg_write    = reg_write_q;
  assign mem_write    = mem_write_q;
  assign illegal_cond = illegal_q;

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] squash_q, squash_d;

  // Both counters saturate at all-ones; stall and flush block accept, so
  // they hold in those cycles.
  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    if (accept) begin
      if (pass) begin
        if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
      end else begin
        if (squash_q != '1) squash_d = squash_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign exec_count   = exec_q;
  assign squash_count = squash_q;
`else
  // Counter width only matters when the counters are built.
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       flush;
  logic       in_valid;
  logic [3:0] cond;
  logic [1:0] flag_write;
  logic [3:0] alu_flags;
  logic       pc_src_in;
  logic       reg_write_in;
  logic       mem_write_in;
  logic       out_valid;
  logic       cond_ex;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_cond;
  logic [3:0] flags;
`ifdef COND_PERF_CNT_EN
  logic [31:0] exec_count;
  logic [31:0] squash_count;
`endif

  int checks = 0;
  int errors = 0;

  cond_unit #(.FLAGS_RESET(4'b0000), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .cond         (cond),
    .flag_write   (flag_write),
    .alu_flags    (alu_flags),
    .pc_src_in    (pc_src_in),
    .reg_write_in (reg_write_in),
    .mem_write_in (mem_write_in),
`ifdef COND_PERF_CNT_EN
    .exec_count   (exec_count),
    .squash_count (squash_count),
`endif
    .out_valid    (out_valid),
    .cond_ex      (cond_ex),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .illegal_cond (illegal_cond),
    .flags        (flags)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one instruction (stall/flush/reset untouched)
  task automatic drive(input logic iv, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic pc, input logic rw,
                       input logic mw);
    in_valid     = iv;
    cond         = c;
    flag_write   = fw;
    alu_flags    = af;
    pc_src_in    = pc;
    reg_write_in = rw;
    mem_write_in = mw;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  // advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected vector: {out_valid, cond_ex, pc_src, reg_write, mem_write, illegal_cond, flags[3:0]}
  task automatic check_out(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {out_valid, cond_ex, pc_src, reg_write, mem_write, illegal_cond, flags};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed ov,ce,pc,rw,mw,il,nzcv=%b required %b", tag, obs, exp);
      $error("%s observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef COND_PERF_CNT_EN
  task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    tick();
    check_out("reset", 10'b000000_0000);
    reset = 1'b0;
    tick();
    check_out("idle", 10'b000000_0000);
`ifdef COND_PERF_CNT_EN
    check_cnt("exec_reset", exec_count, 32'd0);
    check_cnt("squash_reset", squash_count, 32'd0);
`endif

    // AL with register write
    drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("al_rw", 10'b110100_0000);

    // set flags Z, then EQ passes and NE fails
    drive(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0); tick();
    check_out("al_set_z", 10'b110000_0100);
    drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("eq_pass", 10'b110100_0100);
    drive(1'b1, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("ne_fail", 10'b100000_0100);

    // partial flag write
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0); tick();
    check_out("al_set_1111", 10'b110000_1111);
    drive(1'b1, 4'b1110, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0); tick();
    check_out("partial_nz", 10'b110000_0011);
    drive(1'b1, 4'b0000, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0); tick();
    check_out("fail_no_flag_wr", 10'b100000_0011);

    // signed compares with N=1, V=0
    drive(1'b1, 4'b1110, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0); tick();
    check_out("al_set_1000", 10'b110000_1000);
    drive(1'b1, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("ge_fail", 10'b100000_1000);
    drive(1'b1, 4'b1011, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("lt_pass", 10'b110100_1000);
    drive(1'b1, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("gt_fail", 10'b100000_1000);
    drive(1'b1, 4'b1101, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("le_pass", 10'b110100_1000);

    // N=1, V=1
    drive(1'b1, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0); tick();
    check_out("al_set_1001", 10'b110000_1001);
    drive(1'b1, 4'b1010, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("ge_pass", 10'b110100_1001);
    drive(1'b1, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("gt_pass", 10'b110100_1001);
    drive(1'b1, 4'b0010, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("cs_fail", 10'b100000_1001);
    drive(1'b1, 4'b1001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("ls_pass", 10'b110100_1001);

    // stall 3 cycles with a new instruction on the inputs: all held
    stall = 1'b1;
    drive(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall_hold_%0d", i), 10'b110100_1001);
    end
    stall = 1'b0; tick();
    check_out("stall_release", 10'b110010_0110);

    // flush squashes instruction and its flag write
    flush = 1'b1;
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1); tick();
    check_out("flush", 10'b000000_0110);
    flush = 1'b0;

    // flush and stall together: flush wins
    drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
    check_out("pre_flush_stall", 10'b110100_0110);
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b1); tick();
    check_out("flush_stall", 10'b000000_0110);
    flush = 1'b0;
    stall = 1'b0;

`ifdef COND_PERF_CNT_EN
    // passes: 14 accepted-and-passed, 5 accepted-and-failed so far
    check_cnt("exec_pre_illegal", exec_count, 32'd14);
    check_cnt("squash_pre_illegal", squash_count, 32'd5);
`endif

    // reserved condition
    drive(1'b1, 4'b1111, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0); tick();
    check_out("illegal", 10'b100001_0110);
`ifdef COND_PERF_CNT_EN
    check_cnt("exec_post_illegal", exec_count, 32'd14);
    check_cnt("squash_post_illegal", squash_count, 32'd6);
`endif

    // idle clears registered outputs
    idle(); tick();
    check_out("idle_clear", 10'b000000_0110);

    // PC redirect passes through a taken condition (Z=1 in 0110 -> EQ passes)
    drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0); tick();
    check_out("pc_src_pass", 10'b111000_0110);

    // reset mid-stream discards instruction and its flag write
    reset = 1'b1;
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1); tick();
    check_out("reset_mid", 10'b000000_0000);
`ifdef COND_PERF_CNT_EN
    check_cnt("exec_reset_mid", exec_count, 32'd0);
`endif
    reset = 1'b0;
    idle(); tick();
    check_out("after_reset", 10'b000000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer of the ALU's {N,Z,C,V} flag output.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit Arm condition field against it.
- Gates the instruction's writeback, memory-write and PC-redirect enables accordingly.
- Sits between the execute-stage ALU and the memory/writeback stage. All outputs are registered, giving one cycle of latency.

Parameters:
- FLAGS_RESET, 4'b0000, reset value of the NZCV flag register ({N,Z,C,V}).
- CNT_W, 32, width of the performance counters. Used only when COND_PERF_CNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all state; inputs are ignored this cycle
- flush  input  1  squash the incoming instruction
- in_valid  input  1  an instruction is present on the inputs
- cond  input  4  Arm condition field, instruction bits [31:28]
- flag_write  input  2  bit1 = update N,Z; bit0 = update C,V
- alu_flags  input  4  {N,Z,C,V} from the ALU for this instruction
- pc_src_in  input  1  instruction requests a PC redirect
- reg_write_in  input  1  instruction requests a register write
- mem_write_in  input  1  instruction requests a memory write
- out_valid  output  1  registered: an instruction was accepted last cycle
- cond_ex  output  1  registered: the accepted instruction's condition passed
- pc_src  output  1  registered: pc_src_in & cond_ex
- reg_write  output  1  registered: reg_write_in & cond_ex
- mem_write  output  1  registered: mem_write_in & cond_ex
- illegal_cond  output  1  registered: an accepted instruction had cond == 4'b1111
- flags  output  4  current NZCV register, {N,Z,C,V}

Behaviour:
- Priority at each rising edge: reset > flush > stall > normal.
- Reset: flags <= FLAGS_RESET. All other outputs <= 0. Counters (if present) <= 0.
- Accept condition: accept = in_valid & ~stall & ~flush.
- Condition evaluation uses the flag register value before this edge's update. An instruction's own flag write never affects its own condition.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0, with illegal_cond <= 1
- On accept:
  - out_valid <= 1.
  - cond_ex <= pass.
  - Gated enables <= request & pass.
  - If pass: flags[3:2] <= alu_flags[3:2] when flag_write[1]; flags[1:0] <= alu_flags[1:0] when flag_write[0]. Fields whose write bit is clear are unchanged.
- Back-to-back: instruction k+1, accepted on the edge after instruction k, sees k's flag update. No bubble is required.
- Flush, with or without stall:
  - out_valid, cond_ex, all gated enables and illegal_cond <= 0.
  - flags unchanged.
- Stall without flush: every register holds, including the outputs. The consumer sees the same out_valid and enables repeated.
- in_valid = 0, no stall, no flush: out_valid, cond_ex, all enables and illegal_cond <= 0; flags unchanged.
- Reset mid-stream: the instruction on the inputs in the reset cycle is discarded and its flag write is lost.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- When defined, adds two outputs:
  - exec_count [CNT_W-1:0]: increments on every accepted instruction whose condition passes.
  - squash_count [CNT_W-1:0]: increments on every accepted instruction whose condition fails, including cond = 1111.
- Counter rules: both saturate at all-ones. Both clear on reset. Both hold during stall and flush.
- When undefined, the ports and counters do not exist.

Test Plan:
- Reset, then idle: flags = 0000, all outputs 0. Then cond = 1110 (AL), reg_write_in = 1, in_valid = 1 -> next cycle out_valid = 1, cond_ex = 1, reg_write = 1.
- Set-flags sequence: AL with flag_write = 11, alu_flags = 0100; next cycle cond = 0000 (EQ), reg_write_in = 1 -> cond_ex = 1, reg_write = 1. Same with cond = 0001 (NE) -> cond_ex = 0, reg_write = 0.
- Partial flag write: flags = 1111; AL with flag_write = 10, alu_flags = 0000 -> flags = 0011. Failing instruction cond = 0000 with flag_write = 11, alu_flags = 0100 -> flags stay 0011.
- Signed compares: flags = 1000 -> GE fails, LT passes, GT fails, LE passes. Flags = 1001 -> GE passes, GT passes.
- Stall/flush: instruction held with stall = 1 for 3 cycles -> outputs and flags constant. Flush with in_valid = 1, mem_write_in = 1, flag_write = 11 -> out_valid = 0, mem_write = 0, flags unchanged. Assert flush and stall together -> flush wins.
- cond = 1111 with pc_src_in = 1 -> illegal_cond = 1, pc_src = 0, cond_ex = 0. With COND_PERF_CNT_EN, squash_count increments by 1 and exec_count is unchanged.
